// File: rtl/dcache_flush_walker.sv
// DCache flush engine: walks every (set, way) of the tag array, writes back
// dirty lines, invalidates valid lines, then holds the cache until release.
module dcache_flush_walker #(
    parameter  int NUM_SETS   = 64,
    parameter  int NUM_WAYS   = 2,
    parameter  int LINE_BYTES = 16,
    parameter  int ADDR_W     = 32,
    localparam int INDEX_W    = $clog2(NUM_SETS),
    localparam int WAY_W      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    localparam int OFFSET_W   = $clog2(LINE_BYTES),
    localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cacheBusy,
    input  logic               flushReq,
    output logic               flushReqAck,
    output logic               flushComplete,
    input  logic               flushRelease,
    output logic               flushing,
    output logic               arrayRdEn,
    output logic [INDEX_W-1:0] arrayIndex,
    output logic [WAY_W-1:0]   arrayWay,
    input  logic               arrayRdValid,
    input  logic               arrayRdDirty,
    input  logic [TAG_W-1:0]   arrayRdTag,
    output logic               arrayInvEn,
    output logic               wbReq,
    output logic [ADDR_W-1:0]  wbAddr,
    input  logic               wbAck
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ     = 3'd1,
        S_CHECK    = 3'd2,
        S_WB       = 3'd3,
        S_COMPLETE = 3'd4,
        S_RELEASE  = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [INDEX_W-1:0] r_set;
    logic [WAY_W-1:0]   r_way;
    logic [TAG_W-1:0]   r_tag;

    logic w_accept;
    logic w_dirty_hit;
    logic w_advance;
    logic w_way_last;
    logic w_last;

    assign w_accept    = (r_state == S_IDLE) && flushReq && !cacheBusy;
    assign w_dirty_hit = (r_state == S_CHECK) && arrayRdValid && arrayRdDirty;
    assign w_advance   = ((r_state == S_CHECK) && !(arrayRdValid && arrayRdDirty))
                       || ((r_state == S_WB) && wbAck);
    assign w_way_last  = (r_way == WAY_W'(NUM_WAYS - 1));
    assign w_last      = w_way_last && (r_set == INDEX_W'(NUM_SETS - 1));

    // State, walk counters and the tag of the line being written back
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_set   <= '0;
            r_way   <= '0;
            r_tag   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_set <= '0;
                r_way <= '0;
            end else if (w_advance && !w_last) begin
                if (w_way_last) begin
                    r_way <= '0;
                    r_set <= r_set + INDEX_W'(1);
                end else begin
                    r_way <= r_way + WAY_W'(1);
                end
            end
            if (w_dirty_hit) begin
                r_tag <= arrayRdTag;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_accept) w_state_nxt = S_READ;
            S_READ:     w_state_nxt = S_CHECK;
            S_CHECK: begin
                if (w_dirty_hit)    w_state_nxt = S_WB;
                else if (w_last)    w_state_nxt = S_COMPLETE;
                else                w_state_nxt = S_READ;
            end
            S_WB: begin
                if (wbAck) w_state_nxt = w_last ? S_COMPLETE : S_READ;
            end
            S_COMPLETE: w_state_nxt = S_RELEASE;
            S_RELEASE:  if (flushRelease) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Invalidate clean hits at CHECK and dirty hits on the writeback handshake
    always_comb begin
        flushReqAck   = (r_state == S_IDLE) && !cacheBusy;
        flushComplete = (r_state == S_COMPLETE);
        flushing      = (r_state != S_IDLE);
        arrayRdEn     = (r_state == S_READ);
        arrayInvEn    = ((r_state == S_CHECK) && arrayRdValid && !arrayRdDirty)
                      || ((r_state == S_WB) && wbAck);
        wbReq         = (r_state == S_WB);
        arrayIndex    = r_set;
        arrayWay      = r_way;
        wbAddr        = ADDR_W'({r_tag, r_set}) << OFFSET_W;
    end

endmodule
